// File: rtl/spike_aer_tx.sv
// -----------------------------------------------------------------------------
// spike_aer_tx
//
// Transmit side of the spike I/O path. The CPU writes 32-bit spike words
// (one bit per neuron) into the IO spike-output register. Each write arrives
// here with a one-cycle strobe. Words are buffered in a small FIFO. Each set
// bit is then sent, lowest index first, as one address-event on an external
// 4-phase req/ack link.
//
// Optional feature: define AER_TIMEOUT_EN to enable the ack timeout. Without
// it the handshake waits indefinitely and timeout_err is tied low.
//
// Ports
//   clk          in   1       clock, rising edge
//   reset        in   1       asynchronous, active-high reset
//   spike_word   in   WORD_W  spike word from the IO spike-output register
//   word_valid   in   1       one-cycle write strobe for spike_word
//   word_ready   out  1       FIFO not full
//   aer_addr     out  ADDR_W  neuron index of the current event, stable while aer_req=1
//   aer_req      out  1       4-phase request (registered)
//   aer_ack      in   1       4-phase acknowledge (asynchronous, synchronised here)
//   busy         out  1       FIFO non-empty or handshake engine not idle
//   drop_count   out  16      saturating count of lost words and aborted events
//   timeout_err  out  1       sticky ack-timeout flag
// -----------------------------------------------------------------------------
module spike_aer_tx #(
   parameter int WORD_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] spike_word,
   input  logic              word_valid,
   output logic              word_ready,
   output logic [ADDR_W-1:0] aer_addr,
   output logic              aer_req,
   input  logic              aer_ack,
   output logic              busy,
   output logic [15:0]       drop_count,
   output logic              timeout_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [PTR_W:0] PTR_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W+1)'(FIFO_DEPTH);

   // Stop elaboration on parameter sets the address mapping or the pointer
   // arithmetic cannot support.
   if ((WORD_W != (1 << ADDR_W)) || (FIFO_DEPTH < 2) ||
       ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYC < 1)) begin : g_bad_params
      $error("spike_aer_tx: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_REQ,
      S_REL
   } state_t;

   // ---------------------------------------------------------------------------
   // Lowest set bit index. The loop runs from the top bit down, so the last
   // match wins. That match is the smallest index.
   // ---------------------------------------------------------------------------
   function automatic logic [ADDR_W-1:0] lowest_set(input logic [WORD_W-1:0] v);
      logic [ADDR_W-1:0] idx;
      idx = '0;
      for (int i = WORD_W - 1; i >= 0; i--) begin
         if (v[i]) idx = ADDR_W'(i);
      end
      return idx;
   endfunction

   // ---------------------------------------------------------------------------
   // Word FIFO. The pointers carry one extra wrap bit, so full and empty can
   // be told apart without a separate counter register.
   // ---------------------------------------------------------------------------
   logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr_q;
   logic [PTR_W:0]    rd_ptr_q;
   logic [PTR_W:0]    fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic              more_after_pop;
   logic [WORD_W-1:0] fifo_head;
   logic              push;
   logic              pop;
   logic              drop_word;

   assign fifo_count     = wr_ptr_q - rd_ptr_q;
   assign fifo_empty     = (fifo_count == '0);
   assign fifo_full      = (fifo_count == CNT_DEPTH);
   assign more_after_pop = (fifo_count > PTR_ONE);
   assign fifo_head      = fifo_mem[rd_ptr_q[PTR_W-1:0]];

   // Full is the pre-edge state. A pop in the same cycle does not let a push
   // in, so a word offered while full is counted as dropped.
   assign push       = word_valid & ~fifo_full;
   assign drop_word  = word_valid &  fifo_full;
   assign word_ready = ~fifo_full;

   // NOTE: storage arrays carry no reset. The valid range is defined only by the
   // reset pointers, so the RAM can map to plain memory cells.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= spike_word;
   end

   // NOTE: every clocked register uses non-blocking assignment, so all of them
   // update together from the same pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // ---------------------------------------------------------------------------
   // Acknowledge synchroniser. Every handshake decision uses ack_s only.
   // ---------------------------------------------------------------------------
   logic ack_meta;
   logic ack_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_meta <= 1'b0;
         ack_s    <= 1'b0;
      end else begin
         ack_meta <= aer_ack;
         ack_s    <= ack_meta;
      end
   end

   // ---------------------------------------------------------------------------
   // Handshake engine state
   // ---------------------------------------------------------------------------
   state_t            state_q;
   state_t            state_d;
   logic [WORD_W-1:0] pend_q;
   logic [WORD_W-1:0] pend_d;
   logic [ADDR_W-1:0] addr_d;
   logic              req_d;
   logic [WORD_W-1:0] cur_bit;
   logic              tmo_hit;

   // One-hot mask of the event in flight. It is used to retire that bit from
   // pend once the ack arrives.
   assign cur_bit = WORD_W'(1) << aer_addr;

   // ---------------------------------------------------------------------------
   // Optional ack timeout. The counter runs only while REQ or REL is waiting.
   // It restarts on every state entry. It fires when a single wait lasts
   // TIMEOUT_CYC cycles.
   // ---------------------------------------------------------------------------
`ifdef AER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             timeout_err_q;
   logic             waiting;

   assign waiting = ((state_q == S_REQ) && !ack_s) || ((state_q == S_REL) && ack_s);
   assign tmo_hit = waiting && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if ((state_d != state_q) || !((state_q == S_REQ) || (state_q == S_REL)))
            tmo_cnt_q <= '0;
         else
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
         if (tmo_hit) timeout_err_q <= 1'b1;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Next-state and datapath decode
   // ---------------------------------------------------------------------------
   // NOTE: every output of this block gets a default first. No path can then
   // leave a value unassigned, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      addr_d  = aer_addr;
      req_d   = aer_req;
      pop     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) state_d = S_LOAD;
         end

         S_LOAD: begin
            pop    = 1'b1;
            pend_d = fifo_head;
            if (fifo_head == '0) begin
               // An empty word is consumed without an event.
               state_d = more_after_pop ? S_LOAD : S_IDLE;
            end else begin
               addr_d  = lowest_set(fifo_head);
               req_d   = 1'b1;
               state_d = S_REQ;
            end
         end

         S_REQ: begin
            if (tmo_hit) begin
               req_d   = 1'b0;
               pend_d  = '0;
               state_d = fifo_empty ? S_IDLE : S_LOAD;
            end else if (ack_s) begin
               req_d   = 1'b0;
               pend_d  = pend_q & ~cur_bit;
               state_d = S_REL;
            end
         end

         S_REL: begin
            if (tmo_hit) begin
               pend_d  = '0;
               state_d = fifo_empty ? S_IDLE : S_LOAD;
            end else if (!ack_s) begin
               // The address changes only here and in LOAD. In both places
               // req is low, so the receiver never sees it move under a
               // request.
               if (pend_q != '0) begin
                  addr_d  = lowest_set(pend_q);
                  req_d   = 1'b1;
                  state_d = S_REQ;
               end else if (!fifo_empty) begin
                  state_d = S_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pend_q   <= '0;
         aer_addr <= '0;
         aer_req  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         aer_addr <= addr_d;
         aer_req  <= req_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Drop counter. A full-FIFO discard and a timeout abort can coincide, so
   // the increment can be 2. The sum saturates at all-ones.
   // ---------------------------------------------------------------------------
   logic [15:0] drop_q;
   logic [1:0]  drop_inc;
   logic [16:0] drop_sum;

   assign drop_inc = {1'b0, drop_word} + {1'b0, tmo_hit};
   assign drop_sum = {1'b0, drop_q} + {15'b0, drop_inc};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) drop_q <= '0;
      else       drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   assign drop_count = drop_q;
   assign busy       = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_spike_aer_tx.sv
// -----------------------------------------------------------------------------
// tb_spike_aer_tx
//
// Directed bench for spike_aer_tx. The main sequence runs in one initial
// block. An acknowledge responder with a programmable delay runs beside it.
// A link monitor logs one event per rising edge of aer_req, and checks that
// aer_addr stays stable while aer_req is held.
// Define AER_TIMEOUT_EN for both files to cover the timeout path.
// -----------------------------------------------------------------------------
module tb_spike_aer_tx;

   localparam int WORD_W      = 32;
   localparam int ADDR_W      = 5;
   localparam int FIFO_DEPTH  = 4;
   localparam int TIMEOUT_CYC = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [WORD_W-1:0] spike_word;
   logic              word_valid;
   logic              word_ready;
   logic [ADDR_W-1:0] aer_addr;
   logic              aer_req;
   logic              aer_ack;
   logic              busy;
   logic [15:0]       drop_count;
   logic              timeout_err;

   int n_assert = 0;
   int n_fail   = 0;

   logic              resp_en    = 1'b0;
   int                resp_delay = 3;
   logic [ADDR_W-1:0] ev_addr [64];
   int                ev_n      = 0;
   logic              req_prev  = 1'b0;
   logic [ADDR_W-1:0] addr_prev = '0;
   int                hi;

   spike_aer_tx #(
      .WORD_W      (WORD_W),
      .ADDR_W      (ADDR_W),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .spike_word  (spike_word),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .aer_addr    (aer_addr),
      .aer_req     (aer_req),
      .aer_ack     (aer_ack),
      .busy        (busy),
      .drop_count  (drop_count),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n;
      n = 0;
      while ((busy || aer_req) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(busy | aer_req), 32'd0);
   endtask

   task automatic wait_req(input int budget, input string tag);
      int n;
      n = 0;
      while (!aer_req && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(aer_req), 32'd1);
   endtask

   // Acknowledge responder. It raises ack resp_delay cycles after seeing req.
   // It lowers ack resp_delay cycles after req falls.
   initial begin
      aer_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_en && aer_req && !aer_ack) begin
            repeat (resp_delay) @(negedge clk);
            aer_ack = 1'b1;
            while (aer_req && resp_en) @(negedge clk);
            repeat (resp_delay) @(negedge clk);
            aer_ack = 1'b0;
         end
      end
   end

   // Link monitor: log events, check return-to-zero and address stability.
   initial begin
      forever begin
         @(negedge clk);
         if (aer_req && !req_prev) begin
            if (ev_n < 64) ev_addr[ev_n] = aer_addr;
            ev_n++;
            check("req_rise_ack_low", 32'(aer_ack), 32'd0);
         end
         if (aer_req && req_prev) check("addr_stable", 32'(aer_addr), 32'(addr_prev));
         req_prev  = aer_req;
         addr_prev = aer_addr;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      word_valid = 1'b0;
      spike_word = '0;

      // ---- Reset state ----
      repeat (3) @(negedge clk);
      check("rst_word_ready",  32'(word_ready),  32'd1);
      check("rst_busy",        32'(busy),        32'd0);
      check("rst_req",         32'(aer_req),     32'd0);
      check("rst_addr",        32'(aer_addr),    32'd0);
      check("rst_drop",        32'(drop_count),  32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // ---- 0x00000005, 3-cycle responder: events 0 then 2, exact latency ----
      resp_en    = 1'b1;
      resp_delay = 3;
      ev_n       = 0;
      spike_word = 32'h0000_0005;
      word_valid = 1'b1;
      @(negedge clk);                         // edge N accepted the push
      word_valid = 1'b0;
      check("lat_busy_n1",  32'(busy),    32'd1);
      check("lat_req_n1",   32'(aer_req), 32'd0);
      @(negedge clk);                         // after N+1: LOAD
      check("lat_req_n2",   32'(aer_req), 32'd0);
      @(negedge clk);                         // after N+2: REQ
      check("lat_req_n3",   32'(aer_req), 32'd1);
      check("lat_addr_n3",  32'(aer_addr), 32'd0);
      wait_idle(400, "w5_idle");
      check("w5_events",    32'(ev_n),       32'd2);
      check("w5_ev0",       32'(ev_addr[0]), 32'd0);
      check("w5_ev1",       32'(ev_addr[1]), 32'd2);
      check("w5_busy_low",  32'(busy),       32'd0);

      // ---- 0xFFFFFFFF then 0x80000001: 34 events in order ----
      resp_delay = 1;
      ev_n       = 0;
      spike_word = 32'hFFFF_FFFF;
      word_valid = 1'b1;
      @(negedge clk);
      spike_word = 32'h8000_0001;
      @(negedge clk);
      word_valid = 1'b0;
      wait_idle(3000, "ff_idle");
      check("ff_events", 32'(ev_n), 32'd34);
      for (int i = 0; i < 32; i++) check("ff_ev_seq", 32'(ev_addr[i]), 32'(i));
      check("ff_ev32", 32'(ev_addr[32]), 32'd0);
      check("ff_ev33", 32'(ev_addr[33]), 32'd31);
      check("ff_drop", 32'(drop_count),  32'd0);

      // ---- Stall ack, push 6 words: 1 in pend, 4 in FIFO, 1 dropped ----
      resp_en = 1'b0;
      ev_n    = 0;
      for (int i = 0; i < 6; i++) begin
         spike_word = 32'(1) << i;
         word_valid = 1'b1;
         @(negedge clk);
         if (i == 3) check("stall_ready_after4", 32'(word_ready), 32'd1);
         if (i == 4) check("stall_ready_after5", 32'(word_ready), 32'd0);
      end
      word_valid = 1'b0;
      check("stall_drop",  32'(drop_count), 32'd1);
      check("stall_req",   32'(aer_req),    32'd1);
      check("stall_addr",  32'(aer_addr),   32'd0);
      resp_en    = 1'b1;
      resp_delay = 2;
      wait_idle(2000, "stall_idle");
      check("stall_events", 32'(ev_n), 32'd5);
      for (int i = 0; i < 5; i++) check("stall_ev_seq", 32'(ev_addr[i]), 32'(i));
      check("stall_drop_after", 32'(drop_count), 32'd1);

      // ---- All-zero word: busy pulses, no event, drop unchanged ----
      ev_n       = 0;
      spike_word = 32'h0000_0000;
      word_valid = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      check("zero_busy_n1", 32'(busy), 32'd1);
      @(negedge clk);
      check("zero_busy_n2", 32'(busy), 32'd1);
      @(negedge clk);
      check("zero_busy_n3", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      check("zero_events", 32'(ev_n),       32'd0);
      check("zero_req",    32'(aer_req),    32'd0);
      check("zero_drop",   32'(drop_count), 32'd1);

      // ---- Reset mid-handshake: req drops at once, FIFO emptied ----
      resp_en    = 1'b0;
      ev_n       = 0;
      spike_word = 32'h0000_0001;
      word_valid = 1'b1;
      @(negedge clk);
      spike_word = 32'h0000_0002;
      @(negedge clk);
      word_valid = 1'b0;
      wait_req(20, "mid_req_seen");
      #2;
      reset = 1'b1;
      #1;
      check("mid_req_async", 32'(aer_req),    32'd0);
      check("mid_busy",      32'(busy),       32'd0);
      check("mid_ready",     32'(word_ready), 32'd1);
      check("mid_drop",      32'(drop_count), 32'd0);
      check("mid_addr",      32'(aer_addr),   32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_post_req",    32'(aer_req), 32'd0);
      check("mid_post_busy",   32'(busy),    32'd0);
      check("mid_post_events", 32'(ev_n),    32'd1);

`ifdef AER_TIMEOUT_EN
      // ---- Timeout: ack never rises, push 0x3 ----
      resp_en    = 1'b0;
      ev_n       = 0;
      spike_word = 32'h0000_0003;
      word_valid = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      wait_req(20, "tmo_req_seen");
      hi = 0;
      while (aer_req && hi < 100) begin
         hi++;
         @(negedge clk);
      end
      check("tmo_req_cycles", 32'(hi),          32'd16);
      check("tmo_err",        32'(timeout_err), 32'd1);
      check("tmo_drop",       32'(drop_count),  32'd1);
      check("tmo_busy",       32'(busy),        32'd0);
      repeat (5) @(negedge clk);
      check("tmo_events",     32'(ev_n),        32'd1);
      // Recovery on the next word.
      resp_en    = 1'b1;
      resp_delay = 1;
      ev_n       = 0;
      spike_word = 32'h0000_0004;
      word_valid = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      wait_idle(400, "tmo_rec_idle");
      check("tmo_rec_events", 32'(ev_n),        32'd1);
      check("tmo_rec_ev0",    32'(ev_addr[0]),  32'd2);
      check("tmo_err_sticky", 32'(timeout_err), 32'd1);
`else
      check("timeout_err_tied", 32'(timeout_err), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
